// File: rtl/std_sync_fifo_pkg.sv
// std_sync_fifo_pkg: shared constant function for deriving address widths
package std_sync_fifo_pkg;
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/std_sync_fifo_mem.sv
// std_sync_fifo_mem: simple dual-port RAM, one write port and one registered read port
// ports: clk, rst (clears only the read register), we/waddr/wdata write, re/raddr read, rdata registered
module std_sync_fifo_mem
    import std_sync_fifo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    localparam int AW = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    // read-before-write: a same-address read this edge returns the old word
    always_ff @(posedge clk or posedge rst)
        if (rst) rdata <= '0;
        else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/std_sync_fifo.sv
// std_sync_fifo: single-clock FIFO with registered read, occupancy count and full/empty/almost flags
// ports: rst (async, active-high), clk, push/d write, pop/q read (one-cycle latency),
//        full, empty, count, almost_empty, almost_full; with STD_SYNC_FIFO_ERR_FLAGS_EN also
//        sticky overflow and underflow
module std_sync_fifo
    import std_sync_fifo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int ALMOST_FULL_MARGIN = 2,
    parameter int ALMOST_EMPTY_MARGIN = 2,
    localparam int AW = clog2(DEPTH)
) (
    input  logic             rst,
    input  logic             clk,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count,
    output logic             almost_empty,
    output logic             almost_full
`ifdef STD_SYNC_FIFO_ERR_FLAGS_EN
    ,
    output logic             overflow,
    output logic             underflow
`endif
);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_LVL = (AW+1)'(DEPTH - ALMOST_FULL_MARGIN);
    localparam logic [AW:0] AE_LVL = (AW+1)'(ALMOST_EMPTY_MARGIN);

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic push_ok, pop_ok;

    assign pop_ok = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    assign empty = count == '0;
    assign full = count == FULL_LVL;
    assign almost_empty = count <= AE_LVL;
    assign almost_full = count >= AF_LVL;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
        end

    std_sync_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
        .clk(clk),
        .rst(rst),
        .we(push_ok),
        .waddr(wr_ptr),
        .wdata(d),
        .re(pop_ok),
        .raddr(rd_ptr),
        .rdata(q)
    );

`ifdef STD_SYNC_FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            overflow <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push && full && !pop_ok) begin
                overflow <= 1'b1;
                $display("%0t std_sync_fifo: overflow", $time);
            end
            if (pop && empty) begin
                underflow <= 1'b1;
                $display("%0t std_sync_fifo: underflow", $time);
            end
        end
`endif
endmodule

// File: tb/tb_std_sync_fifo.sv
// tb_std_sync_fifo: scoreboard bench for std_sync_fifo (WIDTH=8, DEPTH=32)
module tb_std_sync_fifo;
    logic clk = 1'b0, rst = 1'b1, push = 1'b0, pop = 1'b0;
    logic [7:0] d = '0, q;
    logic full, empty, almost_empty, almost_full;
    logic [5:0] count;
`ifdef STD_SYNC_FIFO_ERR_FLAGS_EN
    logic overflow, underflow;
    logic m_ovf = 1'b0, m_unf = 1'b0;
`endif
    int checks = 0, failures = 0;
    logic [7:0] mdl[$];
    logic [7:0] sb[$];
    logic [7:0] last_q = '0;

    always #5 clk = ~clk;

    std_sync_fifo #(.WIDTH(8), .DEPTH(32)) dut (
        .rst(rst), .clk(clk), .push(push), .pop(pop), .d(d), .q(q),
        .full(full), .empty(empty), .count(count),
        .almost_empty(almost_empty), .almost_full(almost_full)
`ifdef STD_SYNC_FIFO_ERR_FLAGS_EN
        , .overflow(overflow), .underflow(underflow)
`endif
    );

    task automatic chk(input string tag, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic chk_state();
        int sz;
        sz = mdl.size();
        chk("count", int'(count), sz);
        chk("empty", int'(empty), int'(sz == 0));
        chk("full", int'(full), int'(sz == 32));
        chk("almost_empty", int'(almost_empty), int'(sz <= 2));
        chk("almost_full", int'(almost_full), int'(sz >= 30));
`ifdef STD_SYNC_FIFO_ERR_FLAGS_EN
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("underflow", int'(underflow), int'(m_unf));
`endif
    endtask

    task automatic step(input logic p, input logic r, input logic [7:0] dv);
        int sz;
        logic pok, wok;
        push = p;
        pop = r;
        d = dv;
        sz = mdl.size();
        pok = r && sz != 0;
        wok = p && (sz != 32 || pok);
`ifdef STD_SYNC_FIFO_ERR_FLAGS_EN
        if (p && sz == 32 && !pok) m_ovf = 1'b1;
        if (r && sz == 0) m_unf = 1'b1;
`endif
        if (pok) sb.push_back(mdl.pop_front());
        if (wok) mdl.push_back(dv);
        @(posedge clk);
        #1;
        if (sb.size() != 0) last_q = sb.pop_front();
        chk(pok ? "q_pop" : "q_hold", int'(q), int'(last_q));
        chk_state();
        push = 1'b0;
        pop = 1'b0;
    endtask

    task automatic async_reset();
        #3 rst = 1'b1;
        #1;
        mdl.delete();
        sb.delete();
        last_q = '0;
`ifdef STD_SYNC_FIFO_ERR_FLAGS_EN
        m_ovf = 1'b0;
        m_unf = 1'b0;
`endif
        chk("rst_q", int'(q), 0);
        chk_state();
        #10 rst = 1'b0;
    endtask

    initial begin
        #12;
        chk("init_q", int'(q), 0);
        chk_state();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'hE0 + i));
        async_reset();
        step(1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 32; i++) step(1'b1, 1'b0, 8'(i));
        chk("filled", int'(full), 1);
        step(1'b1, 1'b0, 8'hAA);
        step(1'b1, 1'b1, 8'hBB);
        chk("full_pp_q", int'(q), 8'h00);
        for (int i = 0; i < 32; i++) step(1'b0, 1'b1, 8'h00);
        chk("bb_last", int'(q), 8'hBB);
        step(1'b1, 1'b1, 8'h55);
        step(1'b0, 1'b1, 8'h00);
        chk("q55", int'(q), 8'h55);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'h10 + i));
        for (int i = 0; i < 100; i++)
            step(1'b1, 1'b1, 8'($urandom_range(0, 255)));
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h00);
`ifdef STD_SYNC_FIFO_ERR_FLAGS_EN
        step(1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b0, 8'h01);
        chk("unf_sticky", int'(underflow), 1);
        async_reset();
        chk("unf_clr", int'(underflow), 0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/std_sync_fifo.md
Name: std_sync_fifo

Overview:
- Single-clock, first-word-fall-through-free (registered-read) FIFO with push/pop strobes, occupancy count and full/empty/almost flags.
- Used as a general buffering primitive, e.g. the overflow queue in the intermediator (WIDTH = 66+66+row bits, DEPTH = 32). There, pop is issued in one stage and q is consumed exactly one cycle later.

Parameters:
- WIDTH, 32, data word width in bits (first positional parameter).
- DEPTH, 32, number of entries; must be a power of two ≥ 2 (second positional parameter).
- ALMOST_FULL_MARGIN, 2, almost_full asserts when count ≥ DEPTH − ALMOST_FULL_MARGIN.
- ALMOST_EMPTY_MARGIN, 2, almost_empty asserts when count ≤ ALMOST_EMPTY_MARGIN.
- Derived constant AW = log2(DEPTH); count is AW+1 bits.

Ports:
- rst  in  1  reset, asynchronous, active-high
- clk  in  1  clock, rising edge
- push  in  1  write strobe; d captured this edge if accepted
- pop  in  1  read strobe; head entry appears on q after this edge if accepted
- d  in  WIDTH  write data
- q  out  WIDTH  registered read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- count  out  AW+1  current occupancy
- almost_empty  out  1  count ≤ ALMOST_EMPTY_MARGIN
- almost_full  out  1  count ≥ DEPTH − ALMOST_FULL_MARGIN
- Port order is exactly as listed; positional instantiation relies on it.
- Any output may be left unconnected.

Behaviour:
- Reset is asynchronous and active-high. While rst = 1:
  - wr_ptr, rd_ptr and count are 0; q = 0.
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - Memory contents are not cleared.
- Reset mid-operation discards all entries immediately. The first edge after rst deasserts behaves as an empty FIFO.
- Accept rules, evaluated per edge:
  - push_ok = push && (!full || pop_ok).
  - pop_ok = pop && !empty.
- push_ok: mem[wr_ptr] ← d; wr_ptr ← wr_ptr+1, wrapping modulo DEPTH.
- pop_ok: q ← mem[rd_ptr]; rd_ptr ← rd_ptr+1, wrapping.
  - Read latency is one cycle: q is valid in the cycle after the pop edge.
  - q holds its value until the next accepted pop.
- Pop on empty is ignored: no pointer change, q holds.
  - Push and pop on the same edge while empty: the push is accepted, the pop is ignored, count becomes 1.
- Push on full without pop is ignored; the data is dropped and no state changes.
  - Push and pop on the same edge while full: both are accepted and count stays at DEPTH.
- Push and pop on the same edge, non-empty and non-full: both are accepted, count is unchanged, and q receives the old head (not d).
- count ← count + push_ok − pop_ok.
- All flags are decoded combinationally from the registered count. They are glitch-free with respect to clk and valid in the same cycle as count.
- Storage must infer block RAM or distributed RAM: one write port, one synchronous read port, no reset on the array.

Optional Feature:
- Macro: STD_SYNC_FIFO_ERR_FLAGS_EN.
- When defined, two extra output ports are appended after almost_full:
  - overflow (1 bit): sticky; set on push while full && !pop_ok.
  - underflow (1 bit): sticky; set on pop while empty.
  - Both are cleared only by rst.
  - Each setting event also emits a simulation $display with the time.
- When undefined, these ports and their logic do not exist. Ignored push and pop remain silent, as specified above.

Decomposition:
- Shared package (common definitions): the log2/clog2 constant function, used to derive AW from DEPTH.
- One natural sub-module: std_sync_fifo_mem.
  - Simple dual-port RAM, parameters WIDTH and DEPTH.
  - Write port: we, waddr, wdata. Read port: re, raddr, registered rdata.
  - Pointer, count and flag logic stay in std_sync_fifo.

Test Plan:
- Reset/idle: assert rst asynchronously mid-cycle with 5 entries held → empty=1, count=0, q=0 immediately, before the next edge. After release, pop → q stays 0.
- Fill/drain ordering (WIDTH=8, DEPTH=32): push 0x00..0x1F on consecutive cycles → full=1 and count=32 after the 32nd edge. Then pop 32 times → q = 0x00..0x1F, each value one cycle after its pop, and empty=1 at the end.
- Full boundary: with count=32, push 0xAA without pop → count stays 32 and 0xAA is never output. Then push 0xBB with pop on the same edge → count 32, q = oldest entry, and 0xBB is last out.
- Empty boundary: with count=0, push 0x55 with pop on the same edge → count=1, q unchanged. Next edge pop → q=0x55, empty=1.
- Flags: push one at a time and check almost_empty drops at count=3 and almost_full rises at count=30.
- Wrap-around: do 100 interleaved push/pop cycles at count≈3 → data order is preserved across the pointer wrap. With STD_SYNC_FIFO_ERR_FLAGS_EN defined, a pop on empty sets underflow=1, and it stays set until rst.
